// File: rtl/conv1d_mac_sched.sv
// Pipelined signed dot-product engine: radix-4 Booth partial products, carry-save
// compression, then carry-propagate accumulate, sequenced by a four-state job FSM.
module conv1d_mac_sched #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_ACC  = 40,
  parameter int WIDTH_LEN  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH_LEN-1:0]  cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_DATA-1:0] in_x,
  input  logic [WIDTH_DATA-1:0] in_w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_ACC-1:0]  out_acc,
  output logic                  busy
);

  localparam int WIDTH_PROD = 2 * WIDTH_DATA;
  localparam int NUM_PP     = WIDTH_DATA / 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [WIDTH_LEN-1:0]   remaining_reg;
  logic [WIDTH_ACC-1:0]   acc_reg;
  logic [WIDTH_ACC-1:0]   out_acc_reg;
  logic                   s1_valid_reg;
  logic                   s2_valid_reg;
  logic [WIDTH_PROD-1:0]  pp_reg  [NUM_PP];
  logic [WIDTH_PROD-1:0]  pp_next [NUM_PP];
  logic [WIDTH_PROD-1:0]  csa_sum, csa_carry, csa_tmp;
  logic [WIDTH_PROD-1:0]  s2_sum_reg, s2_carry_reg;
  logic [WIDTH_PROD-1:0]  product;
  logic [WIDTH_ACC-1:0]   product_ext;
  logic [WIDTH_PROD-1:0]  x_ext, x_neg, x_dbl, x_dbl_neg;
  logic [WIDTH_DATA:0]    w_pad;
  logic                   xfer;
  logic                   job_start;

  assign in_ready  = (state_reg == RUN) && (remaining_reg != '0);
  assign xfer      = in_valid && in_ready;
  assign job_start = (state_reg == IDLE) && start;
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_acc   = out_acc_reg;

  // Booth recoding: multiplier padded with an implicit zero below its LSB.
  assign x_ext     = {{WIDTH_DATA{in_x[WIDTH_DATA-1]}}, in_x};
  assign x_neg     = -x_ext;
  assign x_dbl     = x_ext << 1;
  assign x_dbl_neg = x_neg << 1;
  assign w_pad     = {in_w, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PP; gi++) begin : g_booth
      logic [2:0]            triplet;
      logic [WIDTH_PROD-1:0] digit_mult;

      assign triplet = w_pad[2*gi+2 -: 3];

      always_comb begin
        digit_mult = '0;
        case (triplet)
          3'b001, 3'b010: digit_mult = x_ext;
          3'b011:         digit_mult = x_dbl;
          3'b100:         digit_mult = x_dbl_neg;
          3'b101, 3'b110: digit_mult = x_neg;
          default:        digit_mult = '0;
        endcase
      end

      assign pp_next[gi] = digit_mult << (2 * gi);

      always_ff @(posedge clk) begin
        pp_reg[gi] <= pp_next[gi];
      end
    end
  endgenerate

  // Chain of 3:2 counters reducing all partial products to one sum/carry pair.
  always_comb begin
    csa_sum   = pp_reg[0];
    csa_carry = pp_reg[1];
    csa_tmp   = '0;
    for (int i = 2; i < NUM_PP; i++) begin
      csa_tmp   = ((csa_sum & csa_carry) | (csa_sum & pp_reg[i]) | (csa_carry & pp_reg[i])) << 1;
      csa_sum   = csa_sum ^ csa_carry ^ pp_reg[i];
      csa_carry = csa_tmp;
    end
  end

  assign product     = s2_sum_reg + s2_carry_reg;
  assign product_ext = {{(WIDTH_ACC-WIDTH_PROD){product[WIDTH_PROD-1]}}, product};

  always_ff @(posedge clk) begin
    s2_sum_reg   <= csa_sum;
    s2_carry_reg <= csa_carry;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (cfg_len == '0) ? DONE : RUN;
      RUN:     if (xfer && remaining_reg == WIDTH_LEN'(1)) state_next = DRAIN;
      DRAIN:   if (!s1_valid_reg && !s2_valid_reg) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      acc_reg       <= '0;
      out_acc_reg   <= '0;
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s1_valid_reg <= xfer;
      s2_valid_reg <= s1_valid_reg;
      if (job_start) begin
        remaining_reg <= cfg_len;
        acc_reg       <= '0;
      end else begin
        if (xfer) remaining_reg <= remaining_reg - WIDTH_LEN'(1);
        if (s2_valid_reg) acc_reg <= acc_reg + product_ext;
      end
      // The result register only changes on entry to DONE, so it holds elsewhere.
      if (job_start && cfg_len == '0)
        out_acc_reg <= '0;
      else if (state_reg == DRAIN && state_next == DONE)
        out_acc_reg <= acc_reg;
    end
  end

endmodule

// File: tb/tb_conv1d_mac_sched.sv
// Directed bench for conv1d_mac_sched: job latency, Booth arithmetic, result
// handshake, zero-length jobs and mid-job reset recovery.
module tb_conv1d_mac_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_acc;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int cnt;
  logic ready_seen;

  conv1d_mac_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [4:0] len);
    cfg_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] w);
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_x = '0; in_w = '0; out_ready = 1'b0;
    tick(); tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_out_acc",   64'(out_acc),   64'd0);
    rst = 1'b0;
    tick();

    // Single pair: 3 * -5, result visible three edges after acceptance
    start_job(5'd1);
    check("n1_in_ready", 64'(in_ready), 64'd1);
    check("n1_busy",     64'(busy),     64'd1);
    send(16'd3, 16'hFFFB);
    check("n1_ready_drop", 64'(in_ready), 64'd0);
    wait_done(cyc);
    check("n1_latency", 64'(cyc), 64'd3);
    check("n1_out_valid", 64'(out_valid), 64'd1);
    check("n1_out_acc", 64'(out_acc), 64'h00FF_FFFF_FFF1);
    $display("job n=1 acc=%0h latency=%0d", out_acc, cyc);
    ack();
    check("n1_idle_valid", 64'(out_valid), 64'd0);
    check("n1_idle_busy",  64'(busy),      64'd0);
    check("n1_acc_hold",   64'(out_acc),   64'h00FF_FFFF_FFF1);

    // Four most-negative products back to back; in_valid held high throughout
    start_job(5'd4);
    in_valid = 1'b1; in_x = 16'h8000; in_w = 16'h8000;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) cnt++;
      tick();
    end
    in_valid = 1'b0;
    check("n4_ready_cycles", 64'(cnt), 64'd4);
    wait_done(cyc);
    check("n4_out_valid", 64'(out_valid), 64'd1);
    check("n4_out_acc", 64'(out_acc), 64'h0001_0000_0000);
    $display("job n=4 acc=%0h", out_acc);
    ack();

    // Pairs separated by bubbles
    start_job(5'd3);
    send(16'd1, 16'd1);
    check("gap_ready_1", 64'(in_ready), 64'd1);
    tick();
    send(16'd2, 16'd2);
    tick();
    send(16'd3, 16'd3);
    wait_done(cyc);
    check("gap_latency", 64'(cyc), 64'd3);
    check("gap_out_acc", 64'(out_acc), 64'd14);
    $display("job n=3 gaps acc=%0h", out_acc);

    // Hold DONE with out_ready low; start pulse must be ignored
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      cfg_len = 5'd1;
      in_valid = 1'b1; in_x = 16'd100; in_w = 16'd100;
      tick();
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_out_acc",   64'(out_acc),   64'd14);
      check("hold_in_ready",  64'(in_ready),  64'd0);
    end
    start = 1'b0; in_valid = 1'b0;
    ack();
    check("hold_release_valid", 64'(out_valid), 64'd0);
    check("hold_release_busy",  64'(busy),      64'd0);

    // Mixed signs exercising every Booth digit
    start_job(5'd4);
    send(16'd12345, 16'hE57B);
    send(16'hFFFF, 16'hFFFF);
    send(16'h7FFF, 16'h7FFF);
    send(16'h8000, 16'h7FFF);
    wait_done(cyc);
    check("mix_out_acc", 64'(out_acc), 64'(-40'sd83842971) & 64'hFF_FFFF_FFFF);
    $display("job n=4 mixed acc=%0h", out_acc);
    ack();

    // Zero-length job goes straight to DONE with a zero result
    start_job(5'd0);
    check("zero_out_valid", 64'(out_valid), 64'd1);
    check("zero_out_acc",   64'(out_acc),   64'd0);
    ready_seen = in_ready;
    for (int i = 0; i < 3; i++) begin
      tick();
      ready_seen = ready_seen | in_ready;
    end
    ack();
    ready_seen = ready_seen | in_ready;
    check("zero_in_ready_never", 64'(ready_seen), 64'd0);
    $display("job n=0 acc=%0h", out_acc);

    // Reset mid-job, competing with start/in_valid/out_ready on the same edge
    start_job(5'd8);
    send(16'd100, 16'd100);
    send(16'd200, 16'd50);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_acc",   64'(out_acc),   64'd0);
    tick(); tick(); tick();
    check("rst_stays_idle", 64'(busy), 64'd0);
    start_job(5'd1);
    send(16'd7, 16'd6);
    wait_done(cyc);
    check("post_rst_latency", 64'(cyc), 64'd3);
    check("post_rst_out_acc", 64'(out_acc), 64'd42);
    $display("job n=1 after reset acc=%0h", out_acc);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
